// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// The scoreboard entry carries a fixed-width rd; narrower register numbers are zero-extended.
package hazard_pkg;

  localparam int FWD_RF    = 0;
  localparam int EX_IDX    = 0;
  localparam int MEM_IDX   = 1;
  localparam int WB_IDX    = 2;
  localparam int MAX_REG_W = 8;

  typedef struct packed {
    logic                 v;
    logic [MAX_REG_W-1:0] rd;
    logic                 ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// One source operand compared against every scoreboard entry.
// Gives the forwarding select of the youngest match and whether its data is ready yet.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 1,
  parameter int FWD_W      = 2
) (
  input  logic [REG_W-1:0]      src,
  input  logic                  src_use,
  input  sb_entry_t [DEPTH-1:0] entries,
  output logic                  ready,
  output logic [FWD_W-1:0]      fwd_sel
);

  logic found;

  // Scan from EX outwards so the youngest producer wins.
  always_comb begin
    found   = 1'b0;
    ready   = 1'b1;
    fwd_sel = FWD_W'(FWD_RF);
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && src_use && (src != '0) && entries[k].v &&
          (entries[k].rd == MAX_REG_W'(src))) begin
        found   = 1'b1;
        fwd_sel = FWD_W'(k + 1);
        ready   = entries[k].ld ? (k >= LOAD_READY) : (k >= ALU_READY);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and flush controller driven by a scoreboard of in-flight destinations.
// State advances on the falling clock edge, in step with the pipeline registers.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 1,
  parameter int CNT_W      = 32,
  localparam int FWD_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_use,
  input  logic [REG_W-1:0]         id_rd,
  input  logic                     id_regwr,
  input  logic                     id_load,
  input  logic                     id_valid,
  input  logic                     br_taken,
  input  logic                     mem_busy,
  output logic                     stall_if,
  output logic                     stall_id,
  output logic                     bubble,
  output logic                     flush_if,
  output logic [NUM_SRC*FWD_W-1:0] fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  sb_entry_t [DEPTH-1:0]     sb;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*FWD_W-1:0]  fwd_raw;
  logic                      hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_match #(
      .REG_W      (REG_W),
      .DEPTH      (DEPTH),
      .ALU_READY  (ALU_READY),
      .LOAD_READY (LOAD_READY),
      .FWD_W      (FWD_W)
    ) u_match (
      .src     (id_src[i*REG_W +: REG_W]),
      .src_use (id_src_use[i]),
      .entries (sb),
      .ready   (src_ready[i]),
      .fwd_sel (fwd_raw[i*FWD_W +: FWD_W])
    );
  end

  assign hazard = id_valid & ~(&src_ready);

  // A taken branch discards the ID instruction, so it overrides a pending hazard.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    bubble   = 1'b0;
    flush_if = 1'b0;
    fwd_sel  = rst ? '0 : fwd_raw;
    if (rst) begin
      stall_if = 1'b0;
    end else if (mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (br_taken) begin
      flush_if = 1'b1;
      bubble   = 1'b1;
    end else if (hazard) begin
      stall_if = 1'b1;
      bubble   = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      sb <= '0;
    end else if (!mem_busy) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        sb[k] <= sb[k-1];
      end
      sb[EX_IDX] <= '{v:  id_valid & id_regwr & ~bubble,
                      rd: MAX_REG_W'(id_rd),
                      ld: id_load};
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(negedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      if (br_taken) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (hazard) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: default instance plus a DEPTH=4/LOAD_READY=2 instance.
// Expected outputs are queued with each stimulus step and popped when the outputs are sampled.
module tb_pipe_hazard_unit;

  logic        clk;
  logic        rst;
  logic [9:0]  id_src;
  logic [1:0]  id_src_use;
  logic [4:0]  id_rd;
  logic        id_regwr, id_load, id_valid, br_taken, mem_busy;

  logic        stall_if, stall_id, bubble, flush_if;
  logic [3:0]  fwd_sel;
  logic [31:0] stall_cnt, flush_cnt;

  logic        stall_if4, stall_id4, bubble4, flush_if4;
  logic [5:0]  fwd_sel4;
  logic [31:0] stall_cnt4, flush_cnt4;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [3:0]  fwd;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        c4;
    logic        s4;
    logic [31:0] sc4;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    ncmp  = 0;
  int    nfail = 0;

  pipe_hazard_unit u_dut (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_use(id_src_use), .id_rd(id_rd),
    .id_regwr(id_regwr), .id_load(id_load), .id_valid(id_valid), .br_taken(br_taken),
    .mem_busy(mem_busy), .stall_if(stall_if), .stall_id(stall_id), .bubble(bubble),
    .flush_if(flush_if), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_unit #(.DEPTH(4), .LOAD_READY(2)) u_dut4 (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_use(id_src_use), .id_rd(id_rd),
    .id_regwr(id_regwr), .id_load(id_load), .id_valid(id_valid), .br_taken(br_taken),
    .mem_busy(mem_busy), .stall_if(stall_if4), .stall_id(stall_id4), .bubble(bubble4),
    .flush_if(flush_if4), .fwd_sel(fwd_sel4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp({t, ".ctl"}, 32'({stall_if, stall_id, bubble, flush_if}), 32'(e.ctl));
    cmp({t, ".fwd"}, 32'(fwd_sel), 32'(e.fwd));
    cmp({t, ".stall_cnt"}, stall_cnt, e.sc);
    cmp({t, ".flush_cnt"}, flush_cnt, e.fc);
    if (e.c4) begin
      cmp({t, ".d4_stall_if"}, 32'(stall_if4), 32'(e.s4));
      cmp({t, ".d4_stall_cnt"}, stall_cnt4, e.sc4);
    end
  endtask

  // Drive one cycle of ID-stage inputs after the rising edge; state moves on the next falling edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] u,
                      input logic [4:0] rd, input logic wr, input logic ld,
                      input logic br, input logic mb,
                      input logic [3:0] ctl, input logic [3:0] fwd,
                      input logic [31:0] sc, input logic [31:0] fc,
                      input logic c4, input logic s4, input logic [31:0] sc4);
    exp_t e;
    @(posedge clk);
    rst = r; id_valid = v; id_src = {s1, s0}; id_src_use = u;
    id_rd = rd; id_regwr = wr; id_load = ld; br_taken = br; mem_busy = mb;
    e = '{ctl: ctl, fwd: fwd, sc: sc, fc: fc, c4: c4, s4: s4, sc4: sc4};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check();
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_src = '0; id_src_use = '0; id_rd = '0;
    id_regwr = 0; id_load = 0; br_taken = 0; mem_busy = 0;
    repeat (2) @(posedge clk);

    step("reset",    1,1, 0,0,2'b00, 0,0,0, 0,0, 4'b0000,4'h0, 0,0, 1,0,0);
    step("alu_ex",   0,1, 0,0,2'b00, 3,1,0, 0,0, 4'b0000,4'h0, 0,0, 0,0,0);
    step("alu_fwd1", 0,1, 0,3,2'b01, 0,0,0, 0,0, 4'b0000,4'h1, 0,0, 0,0,0);
    step("alu_fwd2", 0,1, 0,3,2'b01, 0,0,0, 0,0, 4'b0000,4'h2, 0,0, 0,0,0);
    step("alu_fwd3", 0,1, 0,3,2'b01, 0,0,0, 0,0, 4'b0000,4'h3, 0,0, 0,0,0);
    step("lw_r4",    0,1, 0,0,2'b00, 4,1,1, 0,0, 4'b0000,4'h0, 0,0, 0,0,0);
    step("lu_stall", 0,1, 4,0,2'b10, 0,0,0, 0,0, 4'b1010,4'h4, 0,0, 0,0,0);
    step("lu_fwd",   0,1, 4,0,2'b10, 0,0,0, 0,0, 4'b0000,4'h8, 1,0, 0,0,0);
    step("lw_r0",    0,1, 0,0,2'b00, 0,1,1, 0,0, 4'b0000,4'h0, 1,0, 0,0,0);
    step("r0_read",  0,1, 0,0,2'b11, 0,0,0, 0,0, 4'b0000,4'h0, 1,0, 0,0,0);
    step("lw_r6",    0,1, 0,0,2'b00, 6,1,1, 0,0, 4'b0000,4'h0, 1,0, 0,0,0);
    step("br_haz",   0,1, 0,6,2'b01, 0,0,0, 1,0, 4'b0011,4'h1, 1,0, 0,0,0);
    step("post_br",  0,0, 0,0,2'b00, 0,0,0, 0,0, 4'b0000,4'h0, 1,1, 0,0,0);
    step("lw_r5",    0,1, 0,0,2'b00, 5,1,1, 0,0, 4'b0000,4'h0, 1,1, 0,0,0);
    for (int i = 0; i < 3; i++)
      step("mem_busy", 0,1, 0,5,2'b01, 0,0,0, 0,1, 4'b1100,4'h1, 1,1, 0,0,0);
    step("mb_stall", 0,1, 0,5,2'b01, 0,0,0, 0,0, 4'b1010,4'h1, 1,1, 0,0,0);
    step("mb_fwd",   0,1, 0,5,2'b01, 0,0,0, 0,0, 4'b0000,4'h2, 2,1, 0,0,0);
    step("lw_r7",    0,1, 0,0,2'b00, 7,1,1, 0,0, 4'b0000,4'h0, 2,1, 0,0,0);
    step("rst_pre",  0,1, 7,0,2'b10, 0,0,0, 0,0, 4'b1010,4'h4, 2,1, 0,0,0);
    step("rst_mid",  1,1, 7,0,2'b10, 0,0,0, 0,0, 4'b0000,4'h0, 3,1, 0,0,0);
    step("rst_rel",  0,1, 7,0,2'b10, 0,0,0, 0,0, 4'b0000,4'h0, 0,0, 1,0,0);
    step("sw_lw",    0,1, 0,0,2'b00, 9,1,1, 0,0, 4'b0000,4'h0, 0,0, 1,0,0);
    step("sw_s1",    0,1, 0,9,2'b01, 0,0,0, 0,0, 4'b1010,4'h1, 0,0, 1,1,0);
    step("sw_s2",    0,1, 0,9,2'b01, 0,0,0, 0,0, 4'b0000,4'h2, 1,0, 1,1,1);
    step("sw_s3",    0,1, 0,9,2'b01, 0,0,0, 0,0, 4'b0000,4'h3, 1,0, 1,0,2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
